// File: rtl/pc_redirect_unit_pkg.sv
// Shared encodings for the fetch front end.
// Holds the PC-control state encoding, the default reset PC and the RV32
// branch/jump codes that the EX-stage detector decodes. The alignment helper
// is shared so the fetch unit and the detector agree on what "misaligned" means.
package pc_redirect_unit_pkg;

  localparam int unsigned XLEN = 32;

  // Default fetch address after reset.
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // PC-control states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } pc_state_e;

  // Branch/jump opcodes seen by the detector.
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;

  // Branch condition codes (funct3).
  typedef enum logic [2:0] {
    BJ_BEQ  = 3'b000,
    BJ_BNE  = 3'b001,
    BJ_BLT  = 3'b100,
    BJ_BGE  = 3'b101,
    BJ_BLTU = 3'b110,
    BJ_BGEU = 3'b111
  } bj_funct3_e;

  // A fetch target is legal only on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [XLEN-1:0] target);
    return (target[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: program-counter register and redirect control for fetch.
//
// After reset the unit idles one cycle in BOOT (no fetch request), then runs.
// Each cycle the PC either advances by 4, holds (stall or instruction memory
// busy), or jumps to a resolved branch/jump target. A taken redirect that
// arrives while the instruction memory is busy is parked in a one-entry
// pending slot and applied as soon as the memory is ready. Misaligned taken
// targets raise a trap pulse instead of redirecting.
//
// Ports:
//   CLK, RESET_N    clock, synchronous active-low reset
//   BJ_VALID        branch/jump resolved in EX this cycle
//   PC_SEL          taken flag (qualified by BJ_VALID)
//   BJ_TARGET       branch/jump target address
//   STALL           hazard hold request
//   IMEM_READY      instruction memory accepted/completed the current fetch
//   PC              registered fetch address
//   PC_PLUS4        combinational PC + 4 (wraps modulo 2^32)
//   FETCH_REQ       fetch request, low only in BOOT
//   FLUSH_IFID      one-cycle kill of IF/ID
//   FLUSH_IDEX      one-cycle kill of ID/EX
//   TRAP_MISALIGN   one-cycle pulse on a misaligned taken target
//   REDIRECT_CNT    number of accepted redirects (wrapping)
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        BJ_VALID,
  input  logic        PC_SEL,
  input  logic [31:0] BJ_TARGET,
  input  logic        STALL,
  input  logic        IMEM_READY,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        FETCH_REQ,
  output logic        FLUSH_IFID,
  output logic        FLUSH_IDEX,
  output logic        TRAP_MISALIGN,
  output logic [31:0] REDIRECT_CNT
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        flush_ifid_q, flush_ifid_d;
  logic        flush_idex_q, flush_idex_d;
  logic        trap_q, trap_d;
  logic [31:0] cnt_q, cnt_d;

  logic redirect;
  logic redirect_ok;

  // PC_SEL means nothing unless the detector marks the slot valid.
  assign redirect    = BJ_VALID && PC_SEL;
  assign redirect_ok = redirect && !is_misaligned(BJ_TARGET);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch. Pulses default low, which is
    // what makes them last exactly one cycle.
    state_d      = state_q;
    pc_d         = pc_q;
    pend_v_d     = pend_v_q;
    pend_tgt_d   = pend_tgt_q;
    flush_ifid_d = 1'b0;
    flush_idex_d = 1'b0;
    trap_d       = 1'b0;
    cnt_d        = cnt_q;

    unique case (state_q)
      ST_BOOT: begin
        // One idle cycle; PC stays at the reset address for the first fetch.
        state_d = ST_RUN;
      end

      default: begin
        if (redirect_ok) begin
          // Any accepted redirect squashes the two younger stages and counts.
          flush_ifid_d = 1'b1;
          flush_idex_d = 1'b1;
          cnt_d        = cnt_q + 32'd1;
          if (IMEM_READY) begin
            // Taken even under STALL. A parked older target is now stale,
            // so the pending slot is dropped.
            pc_d     = BJ_TARGET;
            pend_v_d = 1'b0;
            state_d  = ST_RUN;
          end else begin
            // Newer redirect replaces any older parked one.
            pend_tgt_d = BJ_TARGET;
            pend_v_d   = 1'b1;
            state_d    = ST_WAIT;
          end
        end else begin
          // A misaligned taken target only traps; the PC then behaves as if
          // no redirect had arrived.
          trap_d = redirect;
          if (pend_v_q && IMEM_READY) begin
            pc_d     = pend_tgt_q;
            pend_v_d = 1'b0;
            state_d  = ST_RUN;
          end else if (!IMEM_READY) begin
            state_d = ST_WAIT;
          end else if (STALL) begin
            state_d = ST_RUN;
          end else begin
            pc_d    = PC_PLUS4;
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  // NOTE: synchronous reset lives inside the clocked block and all state is
  // written with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pend_v_q     <= 1'b0;
      pend_tgt_q   <= 32'h0000_0000;
      flush_ifid_q <= 1'b0;
      flush_idex_q <= 1'b0;
      trap_q       <= 1'b0;
      cnt_q        <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_v_q     <= pend_v_d;
      pend_tgt_q   <= pend_tgt_d;
      flush_ifid_q <= flush_ifid_d;
      flush_idex_q <= flush_idex_d;
      trap_q       <= trap_d;
      cnt_q        <= cnt_d;
    end
  end

  assign PC            = pc_q;
  assign PC_PLUS4      = pc_q + 32'd4;
  assign FETCH_REQ     = (state_q != ST_BOOT);
  assign FLUSH_IFID    = flush_ifid_q;
  assign FLUSH_IDEX    = flush_idex_q;
  assign TRAP_MISALIGN = trap_q;
  assign REDIRECT_CNT  = cnt_q;

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET_N, input, 1 bit: synchronous active-low reset, sampled on the rising edge of CLK.
REQ-004 The block SHALL have port BJ_VALID, input, 1 bit: a branch/jump is resolved in EX this cycle.
REQ-005 The block SHALL have port PC_SEL, input, 1 bit: taken flag from the branch/jump detector; meaningful only when BJ_VALID=1.
REQ-006 The block SHALL have port BJ_TARGET, input, 32 bits: computed branch/jump target address.
REQ-007 The block SHALL have port STALL, input, 1 bit: hazard hold request from the hazard unit.
REQ-008 The block SHALL have port IMEM_READY, input, 1 bit: instruction memory has accepted or completed the current fetch.
REQ-009 The block SHALL have port PC, output, 32 bits: current fetch address, registered.
REQ-010 The block SHALL have port PC_PLUS4, output, 32 bits: combinational PC+4, modulo 2^32.
REQ-011 The block SHALL have port FETCH_REQ, output, 1 bit: fetch request; combinational, equal to (state != BOOT).
REQ-012 The block SHALL have port FLUSH_IFID, output, 1 bit: registered one-cycle kill of the IF/ID register.
REQ-013 The block SHALL have port FLUSH_IDEX, output, 1 bit: registered one-cycle kill of the ID/EX register.
REQ-014 The block SHALL have port TRAP_MISALIGN, output, 1 bit: registered one-cycle pulse for a taken target with BJ_TARGET[1:0] != 0.
REQ-015 The block SHALL have port REDIRECT_CNT, output, 32 bits: count of accepted redirects; wraps to 0 after 32'hFFFF_FFFF.

Function
REQ-016 The block SHALL implement the states BOOT, RUN and WAIT; after reset it SHALL spend exactly one cycle in BOOT and then enter RUN unconditionally.
REQ-017 The block SHALL define the redirect event as BJ_VALID && PC_SEL, and SHALL ignore PC_SEL when BJ_VALID=0.
REQ-018 In RUN or WAIT, the block SHALL apply the following rules at each edge in the order listed, and only the first rule that matches SHALL take effect.
REQ-019 Rule 1, misaligned redirect: TRAP_MISALIGN<=1; no flush, no count increment, no pending update; evaluation then continues with rule 4 as if no redirect occurred.
REQ-020 Rule 2, aligned redirect with IMEM_READY=1: PC<=BJ_TARGET; FLUSH_IFID<=1 and FLUSH_IDEX<=1; REDIRECT_CNT increments; state<=RUN. This rule overrides STALL.
REQ-021 Rule 3, aligned redirect with IMEM_READY=0: pend_tgt<=BJ_TARGET and pend_v<=1; both flushes set; count increments; PC held; state<=WAIT. An existing pending entry SHALL be overwritten.
REQ-022 Rule 4, pend_v=1 and IMEM_READY=1: PC<=pend_tgt; pend_v<=0; state<=RUN; no additional flush.
REQ-023 Rule 5, IMEM_READY=0: PC held; state<=WAIT.
REQ-024 Rule 6, STALL=1: PC held; state<=RUN.
REQ-025 Rule 7, otherwise: PC<=PC_PLUS4; state<=RUN.
REQ-026 FLUSH_IFID, FLUSH_IDEX and TRAP_MISALIGN SHALL deassert on the next edge unless they are re-triggered at that edge.
REQ-027 Latency from a redirect input to the new PC visible on the PC output SHALL be 1 cycle, or 1 cycle after IMEM_READY rises when the redirect was pending.
REQ-028 PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-029 When RESET_N=0 at an edge, the block SHALL load PC=RESET_PC, state=BOOT, pend_v=0, pend_tgt=0, FLUSH_IFID=0, FLUSH_IDEX=0, TRAP_MISALIGN=0 and REDIRECT_CNT=0, overriding all other inputs.
REQ-030 A reset asserted while in WAIT SHALL discard any pending redirect.

Structure
REQ-031 The state encodings and the default RESET_PC value SHALL live in the shared encodings include, next to the branch/jump codes.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 The bench SHALL drive RESET_N=0 for 2 cycles, then release with IMEM_READY=1, and SHALL check FETCH_REQ=0 for exactly 1 cycle followed by PC = 0, 4, 8 on successive cycles.
REQ-034 The bench SHALL drive, at PC=8, BJ_VALID=1, PC_SEL=1 and BJ_TARGET=32'h40, and SHALL check PC=32'h40 next, both flushes high for exactly 1 cycle, and REDIRECT_CNT=1.
REQ-035 The bench SHALL drive IMEM_READY=0 with a redirect to 32'h80, and SHALL check PC held, a one-cycle flush pulse, then PC=32'h80 one edge after IMEM_READY=1, then 32'h84.
REQ-036 The bench SHALL drive a redirect to 32'h42 at PC=32'h10, and SHALL check TRAP_MISALIGN high for 1 cycle, PC=32'h14, no flush, and REDIRECT_CNT unchanged.
REQ-037 The bench SHALL drive STALL=1 for 3 cycles at PC=32'h10 and SHALL check PC=32'h10 throughout; then, with STALL=1 and a redirect to 32'h100, it SHALL check PC=32'h100; it SHALL also drive BJ_VALID=0 with PC_SEL=1 and check that the redirect is ignored.
REQ-038 The bench SHALL set RESET_PC=32'hFFFF_FFFC and SHALL check PC_PLUS4=0 and next PC=0.
